mont_mult_arbiter: RTL and testbench

- Shares one Montgomery multiplier core between NUM_REQ independent requesters, for example the squaring and multiplying chains of two exponentiation channels.
- Captures start pulses from the requesters and grants the core round-robin.
- Drives the core operand/result mux select and issues a single-cycle core start.
- Returns a single-cycle done pulse to the requester that owns the operation.
- Sits between the per-channel control FSMs and the shared multiplier datapath.

---
 rtl/mont_mult_arbiter_pkg.sv | 37 +++
 rtl/mont_mult_arbiter_if.sv | 26 ++
 rtl/mont_mult_arbiter_rr_arbiter.sv | 22 ++
 rtl/mont_mult_arbiter.sv | 123 ++++++++++++
 tb/tb_mont_mult_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mont_mult_arbiter_pkg.sv
// Shared types and the round-robin pick helper for mont_mult_arbiter.
// Supports up to 8 requesters; the pick works on an 8-bit padded vector.
package mont_arb_pkg;

  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  // First set bit of pend at or after rr_ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   pend,
                                    input logic [MAX_SEL_W-1:0] rr_ptr,
                                    input int unsigned          n);
    pick_t      r;
    logic [3:0] j;
    r = '0;
    for (int k = 0; k < int'(MAX_REQ); k++) begin
      j = {1'b0, rr_ptr} + 4'(k);
      if (j >= 4'(n)) j = j - 4'(n);
      if ((k < int'(n)) && !r.valid && pend[j[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mont_mult_arbiter_if.sv
// Requester/core handshake bundle between channel FSMs and the shared multiplier.
interface mont_mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned SEL_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_start;
  logic [NUM_REQ-1:0] req_done;
  logic [SEL_W-1:0]   core_sel;
  logic               core_start;
  logic               core_ready;
  logic               busy;
  logic               err_overrun;
  logic               err_spurious;
  logic               err_clear;

  modport master (
    output req_start, core_ready, err_clear,
    input  req_done, core_sel, core_start, busy, err_overrun, err_spurious
  );

  modport slave (
    input  req_start, core_ready, err_clear,
    output req_done, core_sel, core_start, busy, err_overrun, err_spurious
  );
endinterface

// File: rtl/mont_mult_arbiter_rr_arbiter.sv
// Combinational pointer-based round-robin pick over the pending vector.
module rr_arbiter
  import mont_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               valid
);

  pick_t p;

  always_comb p = rr_pick(MAX_REQ'(pend), MAX_SEL_W'(rr_ptr), NUM_REQ);

  // The range guard is always true for a valid pick; it keeps every idx bit in use.
  assign winner = SEL_W'(p.idx);
  assign valid  = p.valid && ({1'b0, p.idx} < 4'(NUM_REQ));

endmodule

// File: rtl/mont_mult_arbiter.sv
// Round-robin owner of a shared Montgomery multiplier core.
// Optional MONT_ARB_GRANT_CNT_EN adds saturating per-requester grant counters.
module mont_mult_arbiter
  import mont_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
`ifdef MONT_ARB_GRANT_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  mont_mult_arbiter_if.slave bus
`ifdef MONT_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);

  state_t             state;
  logic [NUM_REQ-1:0] pend;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   winner;
  logic               win_valid;

  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] clr_mask;
  logic [NUM_REQ-1:0] pend_nxt;
  logic               ovr_ev;
  logic               spur_ev;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  // Owner's pend bit clears at the ISSUE edge; a coincident re-request wins.
  always_comb begin
    own_oh   = NUM_REQ'(1) << owner;
    clr_mask = (state == ISSUE) ? own_oh : '0;
    pend_nxt = (pend & ~clr_mask) | bus.req_start;
    ovr_ev   = |(bus.req_start & pend & ~clr_mask);
    spur_ev  = bus.core_ready && (state != WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pend             <= '0;
      rr_ptr           <= '0;
      owner            <= '0;
      bus.core_sel     <= '0;
      bus.core_start   <= 1'b0;
      bus.req_done     <= '0;
      bus.busy         <= 1'b0;
      bus.err_overrun  <= 1'b0;
      bus.err_spurious <= 1'b0;
    end else if (ce) begin
      bus.core_start <= 1'b0;
      bus.req_done   <= '0;
      pend           <= pend_nxt;

      if (ovr_ev)             bus.err_overrun <= 1'b1;
      else if (bus.err_clear) bus.err_overrun <= 1'b0;

      if (spur_ev)            bus.err_spurious <= 1'b1;
      else if (bus.err_clear) bus.err_spurious <= 1'b0;

      case (state)
        IDLE: begin
          if (win_valid) begin
            owner        <= winner;
            bus.core_sel <= winner;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          bus.core_start <= 1'b1;
          state          <= WAIT;
        end
        WAIT: begin
          if (bus.core_ready) begin
            bus.req_done <= own_oh;
            rr_ptr       <= (owner == SEL_W'(NUM_REQ - 1)) ? '0 : owner + SEL_W'(1);
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MONT_ARB_GRANT_CNT_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

  // Counts grants at the IDLE-to-ISSUE edge; saturates, cleared with the error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ce) begin
      if (bus.err_clear) begin
        cnt <= '0;
      end else if ((state == IDLE) && win_valid) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if ((winner == SEL_W'(i)) && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_mont_mult_arbiter.sv
// Directed self-checking bench for mont_mult_arbiter with two requesters.
module tb_mont_mult_arbiter;

  localparam int unsigned NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_start = 0;

  mont_mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef MONT_ARB_GRANT_CNT_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  mont_mult_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus.slave), .grant_cnt(grant_cnt));
`else
  mont_mult_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge, then settle; counts core_start cycles seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.core_start) n_start++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int exp_owner);
    int i;
    i = 0;
    while (!bus.core_start && i < 30) begin
      tick();
      i++;
    end
    check("start_seen", 32'(bus.core_start), 32'd1);
    check("grant_owner", 32'(bus.core_sel), 32'(exp_owner));
  endtask

  task automatic finish_op(input int exp_owner, input logic [1:0] rereq);
    tick();
    tick();
    tick();
    bus.core_ready = 1'b1;
    bus.req_start  = rereq;
    tick();
    bus.core_ready = 1'b0;
    bus.req_start  = '0;
    check("done_vec", 32'(bus.req_done), 32'(2'b01 << exp_owner));
    check("done_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    ce             = 1'b1;
    bus.req_start  = '0;
    bus.core_ready = 1'b0;
    bus.err_clear  = 1'b0;
    do_reset();

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sel", 32'(bus.core_sel), 32'd0);
    check("rst_start", 32'(bus.core_start), 32'd0);
    check("rst_done", 32'(bus.req_done), 32'd0);
    check("rst_errs", {30'd0, bus.err_overrun, bus.err_spurious}, 32'd0);
`ifdef MONT_ARB_GRANT_CNT_EN
    check("rst_cnt", grant_cnt, 32'd0);
`endif

    // Single request from requester 1: exact latency
    bus.req_start = 2'b10;
    tick();
    bus.req_start = '0;
    check("t1_e0_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t1_e1_sel", 32'(bus.core_sel), 32'd1);
    check("t1_e1_busy", 32'(bus.busy), 32'd1);
    check("t1_e1_start", 32'(bus.core_start), 32'd0);
    tick();
    check("t1_e2_start", 32'(bus.core_start), 32'd1);
    tick();
    check("t1_e3_start", 32'(bus.core_start), 32'd0);
    repeat (10) tick();
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    check("t1_done", 32'(bus.req_done), 32'd2);
    check("t1_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t1_done_pulse", 32'(bus.req_done), 32'd0);
    check("t1_sel_hold", 32'(bus.core_sel), 32'd1);

    // Simultaneous requests from rr_ptr=0
    do_reset();
    bus.req_start = 2'b11;
    tick();
    bus.req_start = '0;
    wait_start(0);
    finish_op(0, 2'b00);
    tick();
    check("t2_back2back_busy", 32'(bus.busy), 32'd1);
    check("t2_back2back_sel", 32'(bus.core_sel), 32'd1);
    wait_start(1);
    finish_op(1, 2'b00);
`ifdef MONT_ARB_GRANT_CNT_EN
    check("t2_cnt", grant_cnt, {16'd1, 16'd1});
`endif

    // Fairness: the owner re-requests at every done
    do_reset();
    bus.req_start = 2'b11;
    tick();
    bus.req_start = '0;
    for (int k = 0; k < 6; k++) begin
      wait_start(k % 2);
      finish_op(k % 2, (k < 4) ? (2'b01 << (k % 2)) : 2'b00);
    end
    check("t3_no_overrun", 32'(bus.err_overrun), 32'd0);

    // Overrun: requester 0 starts three times while requester 1 owns the core
    do_reset();
    bus.req_start = 2'b10;
    tick();
    bus.req_start = '0;
    wait_start(1);
    bus.req_start = 2'b01;
    tick();
    check("t4_no_ovr_yet", 32'(bus.err_overrun), 32'd0);
    tick();
    tick();
    bus.req_start = '0;
    check("t4_ovr", 32'(bus.err_overrun), 32'd1);
    finish_op(1, 2'b00);
    n_start = 0;
    wait_start(0);
    finish_op(0, 2'b00);
    repeat (20) tick();
    check("t4_one_start", 32'(n_start), 32'd1);
    check("t4_ovr_sticky", 32'(bus.err_overrun), 32'd1);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("t4_ovr_clr", 32'(bus.err_overrun), 32'd0);

    // Spurious core_ready in IDLE
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    check("t5_spur", 32'(bus.err_spurious), 32'd1);
    check("t5_no_done", 32'(bus.req_done), 32'd0);
    tick();
    check("t5_no_done2", 32'(bus.req_done), 32'd0);
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    check("t5_spur_clr", 32'(bus.err_spurious), 32'd0);

    // ce low in WAIT masks core_ready and holds state
    do_reset();
    bus.req_start = 2'b01;
    tick();
    bus.req_start = '0;
    wait_start(0);
    ce = 1'b0;
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    repeat (4) tick();
    check("t6_ce_busy", 32'(bus.busy), 32'd1);
    check("t6_ce_done", 32'(bus.req_done), 32'd0);
    check("t6_ce_start_hold", 32'(bus.core_start), 32'd1);
    ce = 1'b1;
    tick();
    check("t6_after_ce_done", 32'(bus.req_done), 32'd0);
    check("t6_after_ce_busy", 32'(bus.busy), 32'd1);
    check("t6_after_ce_spur", 32'(bus.err_spurious), 32'd0);
    finish_op(0, 2'b00);

    // Reset in WAIT drops the operation
    bus.req_start = 2'b10;
    tick();
    bus.req_start = '0;
    wait_start(1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_sel", 32'(bus.core_sel), 32'd0);
    check("t7_start", 32'(bus.core_start), 32'd0);
    check("t7_done", 32'(bus.req_done), 32'd0);
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t7_never_done", 32'(bus.req_done), 32'd0);
      tick();
    end
    check("t7_idle_start", 32'(bus.core_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
